// File: rtl/note_decoder_pkg.sv
// Shared constants, note period table and bin-bound helpers for the note decoder.
// Bins are contiguous; each lower bound is the floor midpoint to the next shorter note.
package note_decoder_pkg;

    localparam int unsigned CNT_W     = 19;
    localparam int unsigned NUM_NOTES = 16;

    // Full square-wave period of each note in 100 MHz clk cycles, A3 (code 0) .. B5 (code F)
    localparam int unsigned NOTE_PERIOD [NUM_NOTES] = '{
        454546, 404956, 382226, 340524, 303370, 286344, 255106, 227272,
        202476, 191114, 170262, 151686, 143174, 127552, 113636, 101238
    };

    localparam int unsigned HI_TOP    = 479_341;
    localparam int unsigned LO_BOTTOM = 95_039;

    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } state_e;

    function automatic int unsigned note_lo(logic [3:0] k);
        if (k == 4'd15) begin
            return LO_BOTTOM;
        end
        return (NOTE_PERIOD[k] + NOTE_PERIOD[k + 4'd1]) / 2;
    endfunction

    function automatic int unsigned note_hi(logic [3:0] k);
        if (k == 4'd0) begin
            return HI_TOP;
        end
        return note_lo(k - 4'd1);
    endfunction

endpackage

// File: rtl/note_decoder_tone_period_meter.sv
// Synchronises the audio line, strobes on each rising edge and counts clk cycles
// since the last strobe, saturating at the silence timeout.
module note_decoder_tone_period_meter
    import note_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             audio_i,
    output logic             strobe_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], audio_i};
            prev_q <= sync_q[1];
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        strobe_o = sync_q[1] & ~prev_q;
        if (strobe_o) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o     = cnt_q;
    assign timeout_o = (cnt_q == CntMax);

endmodule

// File: rtl/note_decoder.sv
// Decodes the period of a live square wave into a 4-bit note code with a stability filter.
// SCALE_SHIFT divides every period bound by 2**SCALE_SHIFT; 0 gives the 100 MHz tables.
module note_decoder
    import note_decoder_pkg::*;
#(
    parameter int unsigned STABLE_COUNT   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter int unsigned SCALE_SHIFT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_in,
    output logic [3:0]       hex,
    output logic             valid,
    output logic             note_change,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned      StabW   = $clog2(STABLE_COUNT + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_COUNT);

    logic             strobe;
    logic             timeout;
    logic [CNT_W-1:0] cnt;

    note_decoder_tone_period_meter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_meter (
        .clk_i    (clk),
        .reset_i  (reset),
        .audio_i  (audio_in),
        .strobe_o (strobe),
        .cnt_o    (cnt),
        .timeout_o(timeout)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pend_q, pend_d;
    logic [3:0]       cand_q, cand_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [3:0]       hex_q, hex_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;

    logic [NUM_NOTES-1:0] bin_hit;
    logic                 bin_any;
    logic [3:0]           bin;

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_bin
        localparam logic [CNT_W-1:0] Lo = CNT_W'(note_lo(4'(g)) >> SCALE_SHIFT);
        localparam logic [CNT_W-1:0] Hi = CNT_W'(note_hi(4'(g)) >> SCALE_SHIFT);
        assign bin_hit[g] = (period_q >= Lo) && (period_q < Hi);
    end

    // Bins never overlap, so at most one bit of bin_hit is set.
    always_comb begin
        bin_any = |bin_hit;
        bin     = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (bin_hit[k]) begin
                bin = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            period_q <= '0;
            pend_q   <= 1'b0;
            cand_q   <= '0;
            stab_q   <= '0;
            hex_q    <= '0;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            cand_q   <= cand_d;
            stab_q   <= stab_d;
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        pend_d   = 1'b0;
        cand_d   = cand_q;
        stab_d   = stab_q;
        hex_d    = hex_q;
        valid_d  = valid_q;
        chg_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (strobe) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (strobe) begin
                    period_d = cnt;
                    pend_d   = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    stab_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Classification of the period latched on the previous cycle.
        if (pend_q) begin
            if (!bin_any) begin
                stab_d = '0;
            end else if (bin == cand_q) begin
                stab_d = (stab_q == StabMax) ? stab_q : stab_q + StabW'(1);
            end else begin
                cand_d = bin;
                stab_d = StabW'(1);
            end
            if (bin_any && (stab_d == StabMax)) begin
                hex_d   = cand_d;
                valid_d = 1'b1;
                chg_d   = !valid_q || (hex_q != cand_d);
            end
        end
    end

    assign hex         = hex_q;
    assign valid       = valid_q;
    assign note_change = chg_q;
    assign period      = period_q;

endmodule
